// File: rtl/slm_frame_sequencer_if.sv
// Handshake and pixel-write bundle between the frame sequencer, the dc32 line FIFO,
// the timing controller and the SLM write datapath.
interface slm_frame_sequencer_if #(
    parameter int unsigned ROW_W = 10,
    parameter int unsigned COL_W = 6
);
    logic             line_of_data_available;
    logic             fifo_rd_en;
    logic [31:0]      fifo_rd_data;
    logic [31:0]      slm_data;
    logic             slm_data_valid;
    logic [ROW_W-1:0] slm_row;
    logic [COL_W-1:0] slm_col;
    logic             buffer_switch_req;
    logic             buffer_switch_done;
    logic             update;
    logic             invert;
    logic             frame_done;
    logic             busy;

    modport master (
        input  line_of_data_available, fifo_rd_data, buffer_switch_done,
        output fifo_rd_en, slm_data, slm_data_valid, slm_row, slm_col,
        output buffer_switch_req, update, invert, frame_done, busy
    );

    modport slave (
        output line_of_data_available, fifo_rd_data, buffer_switch_done,
        input  fifo_rd_en, slm_data, slm_data_valid, slm_row, slm_col,
        input  buffer_switch_req, update, invert, frame_done, busy
    );
endinterface

// File: rtl/slm_frame_sequencer.sv
// Streams one SLM frame row by row from the line FIFO, then swaps buffers and pulses update.
// Define SLM_DC_BALANCE_EN to alternate frame polarity (invert toggles, data XORed).
module slm_frame_sequencer #(
    parameter int unsigned ROWS          = 1024,
    parameter int unsigned WORDS_PER_ROW = 40,
    parameter int unsigned UPDATE_CYCLES = 4,
    parameter int unsigned ROW_W         = 10,
    parameter int unsigned COL_W         = 6
) (
    input logic                   fpga_clk,
    input logic                   reset_all,
    slm_frame_sequencer_if.master bus
);
    localparam int unsigned UPD_W = (UPDATE_CYCLES > 1) ? $clog2(UPDATE_CYCLES) : 1;
    localparam logic [ROW_W-1:0] RowLast = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] ColLast = COL_W'(WORDS_PER_ROW - 1);
    localparam logic [UPD_W-1:0] UpdLast = UPD_W'(UPDATE_CYCLES - 1);

    typedef enum logic [2:0] {
        StWaitLine,
        StReadRow,
        StDrain,
        StSwitch,
        StUpdate
    } state_e;

    state_e           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [COL_W-1:0] col_dly_q;
    logic [UPD_W-1:0] upd_q, upd_d;
    logic             invert_q, invert_d;
    logic             valid_q;
    logic             rd_en;
    logic             switch_req;
    logic             update_pulse;
    logic             frame_done_pulse;

    always_comb begin
        state_d          = state_q;
        row_d            = row_q;
        col_d            = col_q;
        upd_d            = upd_q;
        invert_d         = invert_q;
        rd_en            = 1'b0;
        switch_req       = 1'b0;
        update_pulse     = 1'b0;
        frame_done_pulse = 1'b0;
        unique case (state_q)
            StWaitLine: begin
                if (bus.line_of_data_available) begin
                    state_d = StReadRow;
                    col_d   = '0;
                end
            end
            StReadRow: begin
                rd_en = 1'b1;
                if (col_q == ColLast) begin
                    col_d   = '0;
                    state_d = StDrain;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            StDrain: begin
                if (row_q == RowLast) begin
                    row_d   = '0;
                    state_d = StSwitch;
                end else begin
                    row_d   = row_q + 1'b1;
                    state_d = StWaitLine;
                end
            end
            StSwitch: begin
                // done is only honoured here, so stray acknowledges earlier in the frame are lost
                switch_req = 1'b1;
                if (bus.buffer_switch_done) begin
                    state_d = StUpdate;
                    upd_d   = '0;
`ifdef SLM_DC_BALANCE_EN
                    invert_d = ~invert_q;
`endif
                end
            end
            StUpdate: begin
                update_pulse = 1'b1;
                if (upd_q == UpdLast) begin
                    frame_done_pulse = 1'b1;
                    state_d          = StWaitLine;
                end else begin
                    upd_d = upd_q + 1'b1;
                end
            end
            default: state_d = StWaitLine;
        endcase
    end

    always_ff @(posedge fpga_clk) begin
        if (reset_all) begin
            state_q   <= StWaitLine;
            row_q     <= '0;
            col_q     <= '0;
            col_dly_q <= '0;
            upd_q     <= '0;
            invert_q  <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            upd_q    <= upd_d;
            invert_q <= invert_d;
            valid_q  <= rd_en;
            if (rd_en) begin
                col_dly_q <= col_q;
            end
        end
    end

    // FIFO data arrives one cycle after rd_en, aligned with valid_q and col_dly_q
`ifdef SLM_DC_BALANCE_EN
    assign bus.slm_data = valid_q ? (bus.fifo_rd_data ^ {32{invert_q}}) : 32'h0;
`else
    assign bus.slm_data = valid_q ? bus.fifo_rd_data : 32'h0;
`endif

    assign bus.fifo_rd_en        = rd_en;
    assign bus.slm_data_valid    = valid_q;
    assign bus.slm_row           = row_q;
    assign bus.slm_col           = col_dly_q;
    assign bus.buffer_switch_req = switch_req;
    assign bus.update            = update_pulse;
    assign bus.invert            = invert_q;
    assign bus.frame_done        = frame_done_pulse;
    assign bus.busy              = !((state_q == StWaitLine) && (row_q == '0));
endmodule
